ntt_ctrl: RTL and testbench
===========================

Name: ntt_ctrl

Overview:
Sequencer for the forward NTT (Cooley-Tukey, N=256, Q=8380417) built around the combinational butterfly unit (BU).
Walks all log2(N) stages and issues, per cycle, one butterfly: a read address pair, a twiddle index, and a delayed write-back address pair.
Sits between the coefficient RAM, the twiddle ROM, and the BU plus reduction datapath. It does not touch coefficient data itself.
Start/done handshake towards the top-level polynomial engine; global stall input for RAM arbitration.

Parameters:
N, 256, number of coefficients; power of two.
LOG_N, 8, log2(N); also the number of stages.
PIPE_LAT, 2, cycles from read issue to write-back: 1 for the sync RAM read, 1 for the BU/reduction register; must be ≥1.

Ports:
clk_i  in  1  clock
reset_ni  in  1  synchronous, active-low reset
start_i  in  1  start request; sampled only in IDLE
stall_i  in  1  freeze the whole controller, including the write pipeline
busy_o  out  1  high from RUN entry until the DONE cycle inclusive
done_o  out  1  one-cycle pulse when the last write has been issued
rd_en_o  out  1  read strobe for both coefficient ports
rd_addr_a_o  out  LOG_N  address of a[j]
rd_addr_b_o  out  LOG_N  address of a[j+len]
tw_idx_o  out  LOG_N  twiddle ROM index (k), valid with rd_en_o
wr_en_o  out  1  write strobe for both ports
wr_addr_a_o  out  LOG_N  destination of u+t
wr_addr_b_o  out  LOG_N  destination of u-t
stage_o  out  3  current stage 0..LOG_N-1, for debug

Behaviour:
- Reset (reset_ni=0 at a clock edge):
  - State goes to IDLE.
  - Every output is 0, all counters are 0, and the write-delay pipeline is flushed.
  - Reset mid-operation abandons the transform; no further writes are issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN when start_i=1. start_i is ignored in every other state.
  - RUN: one butterfly per unstalled cycle. Butterfly index b counts 0..N/2-1. After b=N/2-1 the FSM goes to DRAIN.
  - DRAIN: exactly PIPE_LAT unstalled cycles with rd_en_o=0.
    - Then, if stage<LOG_N-1: stage+1, b=0, back to RUN.
    - Otherwise go to DONE.
  - DONE: done_o=1 for one cycle, busy_o still 1; next state is IDLE.
- Address math for stage s, len = N>>(s+1), b in 0..N/2-1:
  - g = b>>(LOG_N-1-s)
  - off = b & (len-1)
  - rd_addr_a = g*2*len + off
  - rd_addr_b = rd_addr_a + len
  - tw_idx = (1<<s) + g, giving k=1..N-1 in Dilithium zeta order.
- Write-back: wr_en_o and wr_addr_a/b_o equal rd_en_o and rd_addr_a/b_o delayed by exactly PIPE_LAT unstalled cycles, implemented as a shift register.
- Hazards:
  - Within a stage every address is read once and written once, so there is no hazard.
  - Between stages, DRAIN guarantees the last write of stage s lands before the first read of stage s+1.
- Stall:
  - While stall_i=1, rd_en_o=0 and wr_en_o=0.
  - The FSM, counters, DRAIN count and write-delay pipeline all hold.
  - On release, operation resumes with the identical address sequence.
  - stall_i in IDLE has no effect. In DONE, stall_i holds DONE with done_o=0; the pulse is emitted on the first unstalled DONE cycle.
- Timing with no stall:
  - busy_o rises the cycle after start is sampled.
  - Total cycles = LOG_N*(N/2+PIPE_LAT) + 1, which is 1041 at the defaults.
  - Exactly LOG_N*N/2 = 1024 read strobes and 1024 write strobes.
- Simultaneous reset and start: reset wins.

Decomposition:
- Package ntt_pkg holds:
  - constants N, LOG_N, Q = 8380417;
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - typedefs coef_addr_t (LOG_N bits) and stage_t (3 bits).
- One sub-module, ntt_addr_gen: combinational map (stage, b) → (addr_a, addr_b, tw_idx). It is reused by the future INTT controller.

Test Plan:
- Reset then start_i pulse, no stall:
  - first strobe has rd_addr 0/128, tw_idx 1;
  - the 128th strobe has 127/255, tw 1;
  - wr_en_o first rises exactly 2 cycles after the first rd_en_o.
- Stage 7 (len=1): the first three issues are (0,1,k=128), (2,3,k=129), (4,5,k=130); the last is (254,255,k=255).
- Full run: count 1024 rd strobes and 1024 wr strobes; done_o pulses once, 1041 cycles after start is sampled. A scoreboard golden-model NTT over a RAM model matches the reference vector.
- stall_i=1 for 5 cycles mid stage 3 and 3 cycles inside DRAIN: no strobes during the stall; the address sequence is unchanged; total time grows by 8.
- Reset asserted at cycle 500: all outputs 0 next cycle; no wr_en_o afterwards; a new start runs from stage 0.
- start_i held high during busy: ignored, no restart; a start_i in the DONE cycle is not captured.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the forward NTT sequencer.
// Ring parameters follow the Dilithium prime field.
package ntt_pkg;
  localparam int N     = 256;
  localparam int LOG_N = 8;
  localparam int Q     = 8380417;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef logic [LOG_N-1:0] coef_addr_t;
  typedef logic [2:0]       stage_t;
endpackage

// File: rtl/ntt_ctrl_if.sv
// Start/done handshake, stall and RAM/ROM strobes of the NTT sequencer.
// master = polynomial engine side, slave = the sequencer.
interface ntt_ctrl_if;
  import ntt_pkg::*;

  logic       start_i;
  logic       stall_i;
  logic       busy_o;
  logic       done_o;
  logic       rd_en_o;
  coef_addr_t rd_addr_a_o;
  coef_addr_t rd_addr_b_o;
  coef_addr_t tw_idx_o;
  logic       wr_en_o;
  coef_addr_t wr_addr_a_o;
  coef_addr_t wr_addr_b_o;
  stage_t     stage_o;

  modport master (
    output start_i, stall_i,
    input  busy_o, done_o, rd_en_o,
    input  rd_addr_a_o, rd_addr_b_o, tw_idx_o,
    input  wr_en_o, wr_addr_a_o, wr_addr_b_o,
    input  stage_o
  );

  modport slave (
    input  start_i, stall_i,
    output busy_o, done_o, rd_en_o,
    output rd_addr_a_o, rd_addr_b_o, tw_idx_o,
    output wr_en_o, wr_addr_a_o, wr_addr_b_o,
    output stage_o
  );
endinterface

// File: rtl/ntt_addr_gen.sv
// Cooley-Tukey butterfly address map: (stage, b) -> pair + twiddle.
// Pure combinational so the INTT sequencer can share it.
module ntt_addr_gen #(
  parameter int N     = ntt_pkg::N,
  parameter int LOG_N = ntt_pkg::LOG_N
) (
  input  logic [2:0]       stage,
  input  logic [LOG_N-2:0] b,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-1:0] tw_idx
);
  logic [LOG_N-1:0] bz;
  logic [LOG_N-1:0] len;
  logic [LOG_N-1:0] grp;
  logic [LOG_N-1:0] off;

  // group = b / len, offset = b % len, pair base = group * 2 * len
  always_comb begin
    bz     = {1'b0, b};
    len    = LOG_N'(N >> (int'(stage) + 1));
    grp    = bz >> (LOG_N - 1 - int'(stage));
    off    = bz & (len - LOG_N'(1));
    addr_a = (grp << (LOG_N - int'(stage))) | off;
    addr_b = addr_a + len;
    tw_idx = (LOG_N'(1) << stage) + grp;
  end
endmodule

// File: rtl/ntt_ctrl.sv
// Forward NTT sequencer: one butterfly per unstalled cycle over all
// stages, with write-back addresses delayed by the datapath latency.
module ntt_ctrl #(
  parameter int N        = ntt_pkg::N,
  parameter int LOG_N    = ntt_pkg::LOG_N,
  parameter int PIPE_LAT = 2
) (
  input logic       clk_i,
  input logic       reset_ni,
  ntt_ctrl_if.slave bus
);
  import ntt_pkg::*;

  localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [LOG_N-2:0] B_LAST = (LOG_N-1)'(N / 2 - 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(PIPE_LAT - 1);
  localparam stage_t STAGE_LAST = stage_t'(LOG_N - 1);

  state_t           st;
  stage_t           stage_q;
  logic [LOG_N-2:0] b_q;
  logic [DCW-1:0]   dc_q;

  logic [LOG_N-1:0] ra;
  logic [LOG_N-1:0] rb;
  logic [LOG_N-1:0] tw;

  logic             wp_en [PIPE_LAT];
  logic [LOG_N-1:0] wp_a  [PIPE_LAT];
  logic [LOG_N-1:0] wp_b  [PIPE_LAT];

  logic rd_act;
  logic rd_en;
  logic wr_en;

  ntt_addr_gen #(
    .N     (N),
    .LOG_N (LOG_N)
  ) u_addr_gen (
    .stage  (stage_q),
    .b      (b_q),
    .addr_a (ra),
    .addr_b (rb),
    .tw_idx (tw)
  );

  // Sequencer: start capture, butterfly walk, drain, done pulse.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      st      <= IDLE;
      stage_q <= '0;
      b_q     <= '0;
      dc_q    <= '0;
    end else if (st == IDLE) begin
      if (bus.start_i) begin
        st      <= RUN;
        stage_q <= '0;
        b_q     <= '0;
        dc_q    <= '0;
      end
    end else if (!bus.stall_i) begin
      unique case (st)
        RUN: begin
          if (b_q == B_LAST) begin
            st   <= DRAIN;
            dc_q <= '0;
          end else begin
            b_q <= b_q + 1'b1;
          end
        end
        DRAIN: begin
          if (dc_q == DC_LAST) begin
            dc_q <= '0;
            if (stage_q == STAGE_LAST) begin
              st <= DONE;
            end else begin
              st      <= RUN;
              stage_q <= stage_q + 1'b1;
              b_q     <= '0;
            end
          end else begin
            dc_q <= dc_q + 1'b1;
          end
        end
        DONE: begin
          st      <= IDLE;
          stage_q <= '0;
          b_q     <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign rd_act = (st == RUN);

  // Write-back delay line: advances only on unstalled cycles.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wp_en[i] <= 1'b0;
        wp_a[i]  <= '0;
        wp_b[i]  <= '0;
      end
    end else if (!bus.stall_i) begin
      wp_en[0] <= rd_act;
      wp_a[0]  <= rd_act ? ra : '0;
      wp_b[0]  <= rd_act ? rb : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wp_en[i] <= wp_en[i-1];
        wp_a[i]  <= wp_a[i-1];
        wp_b[i]  <= wp_b[i-1];
      end
    end
  end

  assign rd_en = rd_act & ~bus.stall_i;
  assign wr_en = wp_en[PIPE_LAT-1] & ~bus.stall_i;

  assign bus.busy_o      = (st != IDLE);
  assign bus.done_o      = (st == DONE) & ~bus.stall_i;
  assign bus.stage_o     = stage_q;
  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_a_o = rd_en ? ra : '0;
  assign bus.rd_addr_b_o = rd_en ? rb : '0;
  assign bus.tw_idx_o    = rd_en ? tw : '0;
  assign bus.wr_en_o     = wr_en;
  assign bus.wr_addr_a_o = wr_en ? wp_a[PIPE_LAT-1] : '0;
  assign bus.wr_addr_b_o = wr_en ? wp_b[PIPE_LAT-1] : '0;
endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: address sequence, write-back timing,
// stalls, reset abort and a full NTT over a RAM model.
module tb_ntt_ctrl;
  import ntt_pkg::*;

  localparam int NN    = 256;
  localparam int HALF  = 128;
  localparam int LG    = 8;
  localparam int PL    = 2;
  localparam int TOTAL = LG * (HALF + PL) + 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ntt_ctrl_if bus();

  ntt_ctrl u_dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus)
  );

  typedef struct {int a; int b; int k;} io_t;
  typedef struct {longint x; longint y;} dat_t;

  io_t    exp_rd[$];
  io_t    exp_wr[$];
  io_t    rd_log[$];
  dat_t   dq[$];
  longint ram   [NN];
  longint ref_a [NN];
  longint zeta  [NN];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt, wr_cnt, done_cnt, busy_cnt, stall_busy, done_at;
  int first_rd, first_wr, post_rst_wr;
  bit mon_en = 1'b0;
  bit after_rst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int brv8(input int k);
    int r = 0;
    for (int i = 0; i < LG; i++) if (k[i]) r |= 1 << (LG - 1 - i);
    return r;
  endfunction

  // Textbook forward NTT, plus the issue order it implies.
  task automatic ref_ntt();
    int k = 0;
    longint t;
    for (int len = HALF; len > 0; len >>= 1)
      for (int s = 0; s < NN; s += 2 * len) begin
        k++;
        for (int j = s; j < s + len; j++) begin
          t = zeta[k] * ref_a[j + len] % Q;
          ref_a[j + len] = (ref_a[j] + Q - t) % Q;
          ref_a[j] = (ref_a[j] + t) % Q;
          exp_rd.push_back('{j, j + len, k});
          exp_wr.push_back('{j, j + len, k});
        end
      end
  endtask

  // Monitor: pops the scoreboard and runs the RAM/butterfly model.
  always @(negedge clk) begin
    io_t e;
    dat_t d;
    longint u, t;
    if (mon_en) begin
      if (bus.busy_o) begin
        busy_cnt++;
        if (bus.stall_i) stall_busy++;
      end
      if (bus.stall_i)
        chk("stall_quiet",
            longint'({bus.rd_en_o, bus.wr_en_o, bus.done_o}), 0);
      if (bus.done_o) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      if (bus.wr_en_o) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        if (after_rst) post_rst_wr++;
        if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_a", longint'(bus.wr_addr_a_o), e.a);
          chk("wr_b", longint'(bus.wr_addr_b_o), e.b);
        end
        if (dq.size() > 0) begin
          d = dq.pop_front();
          ram[bus.wr_addr_a_o] = d.x;
          ram[bus.wr_addr_b_o] = d.y;
        end
      end
      if (bus.rd_en_o) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        rd_log.push_back('{int'(bus.rd_addr_a_o), int'(bus.rd_addr_b_o),
                           int'(bus.tw_idx_o)});
        if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
        else begin
          e = exp_rd.pop_front();
          chk("rd_a", longint'(bus.rd_addr_a_o), e.a);
          chk("rd_b", longint'(bus.rd_addr_b_o), e.b);
          chk("tw", longint'(bus.tw_idx_o), e.k);
        end
        u = ram[bus.rd_addr_a_o];
        t = zeta[bus.tw_idx_o] * ram[bus.rd_addr_b_o] % Q;
        dq.push_back('{(u + t) % Q, (u + Q - t) % Q});
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, longint'(bus.busy_o), 0);
    chk({tag, "_done"}, longint'(bus.done_o), 0);
    chk({tag, "_rd_en"}, longint'(bus.rd_en_o), 0);
    chk({tag, "_wr_en"}, longint'(bus.wr_en_o), 0);
    chk({tag, "_rd_a"}, longint'(bus.rd_addr_a_o), 0);
    chk({tag, "_rd_b"}, longint'(bus.rd_addr_b_o), 0);
    chk({tag, "_tw"}, longint'(bus.tw_idx_o), 0);
    chk({tag, "_wr_ab"},
        longint'({bus.wr_addr_a_o, bus.wr_addr_b_o}), 0);
    chk({tag, "_stage"}, longint'(bus.stage_o), 0);
  endtask

  function automatic logic sched(input int mode, input int c);
    if (mode == 1)
      return (c >= 450 && c <= 454) || (c >= 654 && c <= 656) ||
             (c >= 1049 && c <= 1050);
    if (mode == 2) return ($urandom_range(0, 7) == 0);
    return 1'b0;
  endfunction

  // mode: 0 no stall, 1 fixed stalls, 2 random stalls
  task automatic run(input int mode, input int rst_at, input bit hold);
    int c;
    bit fin;
    exp_rd.delete(); exp_wr.delete(); rd_log.delete(); dq.delete();
    for (int i = 0; i < NN; i++) begin
      ram[i] = longint'($urandom_range(0, Q - 1));
      ref_a[i] = ram[i];
    end
    ref_ntt();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
    stall_busy = 0; done_at = -1; first_rd = -1; first_wr = -1;
    post_rst_wr = 0; after_rst = 1'b0;
    mon_en = 1'b1;
    bus.start_i = 1'b1;
    bus.stall_i = (mode == 2);
    @(posedge clk); #1;
    if (!hold) bus.start_i = 1'b0;
    c = 1;
    fin = 1'b0;
    while (!fin && c < 4000) begin
      bus.stall_i = sched(mode, c);
      if (c == rst_at) reset_n = 1'b0;
      @(posedge clk); #1;
      if (c == rst_at) begin
        bus.stall_i = 1'b0;
        chk_zero("rst_mid");
        reset_n = 1'b1;
        after_rst = 1'b1;
        exp_rd.delete(); exp_wr.delete(); dq.delete();
        fin = 1'b1;
      end else if (done_cnt > 0 && !bus.busy_o) begin
        bus.start_i = 1'b0;
        fin = 1'b1;
      end
      c++;
    end
    bus.stall_i = 1'b0;
    bus.start_i = 1'b0;
    chk("finished_in_budget", longint'(fin), 1);
    if (rst_at > 0) begin
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_wr", post_rst_wr, 0);
      chk("post_rst_busy", longint'(bus.busy_o), 0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      chk("no_restart", longint'(bus.busy_o), 0);
      chk("rd_count", rd_cnt, LG * HALF);
      chk("wr_count", wr_cnt, LG * HALF);
      chk("done_count", done_cnt, 1);
      chk("busy_cycles", busy_cnt, TOTAL + stall_busy);
      chk("done_last_busy", done_at, busy_cnt);
      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      for (int i = 0; i < NN; i++) chk("coef", ram[i], ref_a[i]);
      if (mode == 1) chk("stall_total", stall_busy, 10);
      if (mode == 0 && rd_log.size() == LG * HALF) begin
        chk("wr_latency", first_wr - first_rd, PL);
        chk("s0_first", longint'({rd_log[0].a, rd_log[0].b, rd_log[0].k}),
            longint'({32'd0, 32'd128, 32'd1}));
        chk("s0_last", longint'({rd_log[127].a, rd_log[127].b,
            rd_log[127].k}), longint'({32'd127, 32'd255, 32'd1}));
        for (int i = 0; i < 3; i++)
          chk("s7_head", longint'({rd_log[896+i].a, rd_log[896+i].b,
              rd_log[896+i].k}), longint'({2*i, 2*i+1, 128+i}));
        chk("s7_last", longint'({rd_log[1023].a, rd_log[1023].b,
            rd_log[1023].k}), longint'({32'd254, 32'd255, 32'd255}));
      end
    end
    mon_en = 1'b0;
  endtask

  initial begin
    longint z;
    for (int k = 0; k < NN; k++) begin
      z = 1;
      for (int i = 0; i < brv8(k); i++) z = z * 1753 % Q;
      zeta[k] = z;
    end
    reset_n = 1'b0;
    bus.start_i = 1'b1;
    bus.stall_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    bus.start_i = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", longint'(bus.busy_o), 0);

    run(0, 0, 1'b0);
    run(1, 0, 1'b0);
    run(0, 500, 1'b0);
    run(2, 0, 1'b1);
    run(0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
